// File: rtl/des_mode_ctrl.sv
// ECB/CBC block-cipher mode controller in front of a single-block DES core, with an input FIFO.
// Define DES_MODE_CTR_EN to enable counter mode on mode 2; otherwise mode 2 is reserved.
//
// state   | meaning
// S_IDLE  | waiting for a queued block; pops the head and prepares the core input
// S_ISSUE | core_valid_in asserted for this single cycle
// S_WAIT  | waiting for core_valid_out; result is registered on the strobe
module des_mode_ctrl #(
    parameter int BLOCK_W    = 64,
    parameter int KEY_W      = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [KEY_W-1:0]   cipher_key,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [1:0]         mode,
    input  logic               encrypt_decrypt,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic [BLOCK_W-1:0] text_in,
    output logic               valid_out,
    output logic [BLOCK_W-1:0] text_out,
    output logic               busy,
    output logic               err_mode,
    output logic               core_valid_in,
    output logic [BLOCK_W-1:0] core_text_in,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_encrypt_decrypt,
    input  logic               core_valid_out,
    input  logic [BLOCK_W-1:0] core_text_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CTR_W < 1 || CTR_W > BLOCK_W)
    begin : g_param_err
        $error("des_mode_ctrl: FIFO_DEPTH must be a power of two >= 2 and 1 <= CTR_W <= BLOCK_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [KEY_W-1:0]   key_q;
    logic [1:0]         mode_q;
    logic               dir_q, err_q, valid_out_q;
    logic [BLOCK_W-1:0] chain_q, hold_q, core_in_q, text_out_q;

    logic               push, pop, start_ok, mode_bad, use_cbc, done;
    logic [BLOCK_W-1:0] head, issue_blk, result_blk, chain_nxt;

    assign busy     = (count_q != '0) || (state_q != S_IDLE);
    assign ready_in = (count_q != FULL_CNT);
    assign push     = valid_in && ready_in;
    assign start_ok = start && !busy;
    assign head     = fifo_mem[rd_ptr_q];
    assign use_cbc  = (mode_q == 2'd1);
    assign done     = (state_q == S_WAIT) && core_valid_out;

`ifdef DES_MODE_CTR_EN
    localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);
    logic use_ctr;
    assign use_ctr              = (mode_q == 2'd2);
    assign mode_bad             = (mode == 2'd3);
    assign core_encrypt_decrypt = use_ctr ? 1'b0 : dir_q;
`else
    assign mode_bad             = (mode == 2'd2) || (mode == 2'd3);
    assign core_encrypt_decrypt = dir_q;
`endif

    assign valid_out    = valid_out_q;
    assign text_out     = text_out_q;
    assign err_mode     = err_q;
    assign core_text_in = core_in_q;
    assign core_key     = key_q;

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        core_valid_in = 1'b0;
        issue_blk     = head;
        result_blk    = core_text_out;
        chain_nxt     = chain_q;
        // hold_q keeps the popped block: ciphertext for CBC decrypt, plaintext for CTR
        if (use_cbc) begin
            if (!dir_q) begin
                issue_blk = head ^ chain_q;
                chain_nxt = core_text_out;
            end else begin
                result_blk = core_text_out ^ chain_q;
                chain_nxt  = hold_q;
            end
        end
`ifdef DES_MODE_CTR_EN
        if (use_ctr) begin
            issue_blk  = chain_q;
            result_blk = hold_q ^ core_text_out;
            chain_nxt  = (chain_q & ~CTR_MASK) | ((chain_q + BLOCK_W'(1)) & CTR_MASK);
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_valid_in = 1'b1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid_out) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= text_in;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_q       <= '0;
            mode_q      <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            chain_q     <= '0;
            hold_q      <= '0;
            core_in_q   <= '0;
            text_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= 1'b0;
            if (start_ok) begin
                key_q   <= cipher_key;
                mode_q  <= mode;
                dir_q   <= encrypt_decrypt;
                err_q   <= mode_bad;
                chain_q <= iv;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                core_in_q <= issue_blk;
                hold_q    <= head;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // start is only accepted while idle, so it never collides with a completion
            if (done) begin
                text_out_q  <= result_blk;
                valid_out_q <= 1'b1;
                chain_q     <= chain_nxt;
            end
        end
    end

endmodule

// File: tb/tb_des_mode_ctrl.sv
// Self-checking bench for des_mode_ctrl: stand-in DES core plus a queue-based model of the
// chaining modes, checked by one compare process on every falling edge.
module tb_des_mode_ctrl;

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C0 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h84CB563386A179EA;
    localparam logic [63:0] MIX = 64'hA5A55A5AC3C33C3C;
`ifdef DES_MODE_CTR_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn, start, encrypt_decrypt, valid_in, core_valid_out;
    logic [1:0]  mode;
    logic [63:0] cipher_key, iv, text_in, core_text_out;
    logic        ready_in, valid_out, busy, err_mode, core_valid_in, core_encrypt_decrypt;
    logic [63:0] text_out, core_text_in, core_key;

    des_mode_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .cipher_key(cipher_key), .iv(iv),
        .mode(mode), .encrypt_decrypt(encrypt_decrypt), .valid_in(valid_in),
        .ready_in(ready_in), .text_in(text_in), .valid_out(valid_out), .text_out(text_out),
        .busy(busy), .err_mode(err_mode), .core_valid_in(core_valid_in),
        .core_text_in(core_text_in), .core_key(core_key),
        .core_encrypt_decrypt(core_encrypt_decrypt), .core_valid_out(core_valid_out),
        .core_text_out(core_text_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Stand-in cipher: a keyed bijection that agrees with real DES on the reference pair for K0.
    function automatic logic [63:0] g_enc(logic [63:0] k, logic [63:0] x);
        logic [63:0] r;
        r = x ^ k;
        return {r[56:0], r[63:57]} ^ MIX;
    endfunction

    function automatic logic [63:0] g_dec(logic [63:0] k, logic [63:0] y);
        logic [63:0] r;
        r = y ^ MIX;
        return {r[6:0], r[63:7]} ^ k;
    endfunction

    function automatic logic [63:0] core_enc(logic [63:0] k, logic [63:0] x);
        if (k == K0 && x == P0) return C0;
        if (k == K0 && x == g_dec(k, C0)) return g_enc(k, P0);
        return g_enc(k, x);
    endfunction

    function automatic logic [63:0] core_dec(logic [63:0] k, logic [63:0] y);
        if (k == K0 && y == C0) return P0;
        if (k == K0 && y == g_enc(k, P0)) return g_dec(k, C0);
        return g_dec(k, y);
    endfunction

    // core model: request seen in the ISSUE cycle, answer after a (possibly stalled) latency
    bit core_stall = 1'b0;
    bit core_lat_rand = 1'b0;
    initial begin
        logic [63:0] r;
        int lat;
        core_valid_out = 1'b0;
        core_text_out  = '0;
        forever begin
            @(negedge clk);
            if (core_valid_in) begin
                r = core_encrypt_decrypt ? core_dec(core_key, core_text_in)
                                         : core_enc(core_key, core_text_in);
                @(posedge clk);
                lat = core_lat_rand ? int'($urandom_range(0, 4)) : 0;
                repeat (lat) @(posedge clk);
                while (core_stall) @(posedge clk);
                #1;
                core_valid_out = 1'b1;
                core_text_out  = r;
                @(posedge clk);
                #1;
                core_valid_out = 1'b0;
                core_text_out  = {$urandom, $urandom};
            end
        end
    end

    // behavioural model of the mode rules; expectations are computed when a block is accepted
    logic [1:0]  m_mode = '0;
    logic        m_dir = 1'b0, m_err = 1'b0, exp_dir;
    logic [63:0] m_key = '0, m_chain = '0;
    logic [63:0] exp_core[$], exp_out[$], core_in_log[$], out_log[$];
    int          vo_count = 0;
    int unsigned vo_cyc = 0, last_push_cyc = 0;

    function automatic void model_push(logic [63:0] p);
        logic [63:0] cin, res;
        if (m_mode == 2'd1 && !m_dir) begin
            cin = p ^ m_chain;
            res = core_enc(m_key, cin);
            m_chain = res;
        end else if (m_mode == 2'd1) begin
            cin = p;
            res = core_dec(m_key, p) ^ m_chain;
            m_chain = p;
        end else if (m_mode == 2'd2 && CTR_EN) begin
            cin = m_chain;
            res = p ^ core_enc(m_key, m_chain);
            m_chain = {m_chain[63:32], m_chain[31:0] + 32'd1};
        end else begin
            cin = p;
            res = m_dir ? core_dec(m_key, p) : core_enc(m_key, p);
        end
        exp_core.push_back(cin);
        exp_out.push_back(res);
    endfunction

    initial forever begin
        @(negedge clk);
        check("err_mode", {63'd0, err_mode}, {63'd0, m_err});
        if (core_valid_in) begin
            core_in_log.push_back(core_text_in);
            if (exp_core.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL core_req: unexpected core_valid_in with %h, expected none", core_text_in);
            end else begin
                exp_dir = (m_mode == 2'd2 && CTR_EN) ? 1'b0 : m_dir;
                check("core_text_in", core_text_in, exp_core.pop_front());
                check("core_key", core_key, m_key);
                check("core_dir", {63'd0, core_encrypt_decrypt}, {63'd0, exp_dir});
            end
        end
        if (valid_out) begin
            out_log.push_back(text_out);
            vo_count++;
            vo_cyc = cyc;
            if (exp_out.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_out: unexpected result %h, expected no pulse", text_out);
            end else begin
                check("text_out", text_out, exp_out.pop_front());
            end
        end
        if (!rstn) begin
            exp_core.delete();
            exp_out.delete();
            m_mode = '0; m_dir = 1'b0; m_err = 1'b0; m_key = '0; m_chain = '0;
        end else begin
            if (start && !busy) begin
                m_mode  = mode;
                m_dir   = encrypt_decrypt;
                m_key   = cipher_key;
                m_chain = iv;
                m_err   = (mode == 2'd3) || (mode == 2'd2 && !CTR_EN);
            end
            if (valid_in && ready_in) model_push(text_in);
        end
    end

    // all stimulus tasks start and end at posedge + 1
    task automatic cfg(input logic [1:0] md, input logic dr, input logic [63:0] k,
                       input logic [63:0] v, input bit with_blk, input logic [63:0] b);
        start = 1'b1; mode = md; encrypt_decrypt = dr; cipher_key = k; iv = v;
        if (with_blk) begin
            valid_in = 1'b1;
            text_in  = b;
        end
        @(posedge clk);
        #1;
        if (with_blk) last_push_cyc = cyc;
        start = 1'b0; valid_in = 1'b0;
        cipher_key = {$urandom, $urandom}; iv = {$urandom, $urandom};
        mode = 2'($urandom); encrypt_decrypt = 1'($urandom);
    endtask

    task automatic push_blk(input logic [63:0] b);
        int t = 0;
        valid_in = 1'b1;
        text_in  = b;
        while (!ready_in && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: ready_in stayed 0 for %0d cycles, expected 1", t);
        end
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        valid_in = 1'b0;
        text_in  = {$urandom, $urandom};
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_out.size() != 0 || busy) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_int({tag, "_drain_timeout"}, int'(t >= 400), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        core_in_log.delete();
        out_log.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int acc, vo0;
        logic [1:0]  md;
        logic [63:0] k, v, b;
        rstn = 1'b0; start = 1'b0; mode = '0; encrypt_decrypt = 1'b0;
        cipher_key = '0; iv = '0; valid_in = 1'b0; text_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", {63'd0, valid_out}, 64'd0);
        check("rst_text_out", text_out, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err_mode", {63'd0, err_mode}, 64'd0);
        check("rst_core_valid_in", {63'd0, core_valid_in}, 64'd0);
        check("rst_core_text_in", core_text_in, 64'd0);
        check("rst_core_key", core_key, 64'd0);
        check("rst_core_dir", {63'd0, core_encrypt_decrypt}, 64'd0);
        check("rst_ready_in", {63'd0, ready_in}, 64'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ECB encrypt on the reference vector, zero core latency
        clear_logs();
        cfg(2'd0, 1'b0, K0, 64'd0, 1'b0, 64'd0);
        push_blk(P0);
        drain("ecb");
        check_int("ecb_nout", out_log.size(), 1);
        check("ecb_core_in", core_in_log[0], P0);
        check("ecb_out", out_log[0], C0);
        check_int("ecb_latency", int'(vo_cyc - last_push_cyc), 3);

        // CBC encrypt; first block enqueued in the same cycle as start
        clear_logs();
        cfg(2'd1, 1'b0, K0, 64'd0, 1'b1, P0);
        push_blk(P1);
        drain("cbc_enc");
        check("cbc_enc_core_in1", core_in_log[1], P0);
        check("cbc_enc_out0", out_log[0], C0);
        check("cbc_enc_out1", out_log[1], C0);

        // CBC decrypt
        clear_logs();
        cfg(2'd1, 1'b1, K0, 64'd0, 1'b0, 64'd0);
        push_blk(C0);
        push_blk(C0);
        drain("cbc_dec");
        check("cbc_dec_out0", out_log[0], P0);
        check("cbc_dec_out1", out_log[1], P1);

        // backpressure with the core stalled
        clear_logs();
        cfg(2'd0, 1'b0, K0, 64'd0, 1'b0, 64'd0);
        core_stall = 1'b1;
        acc = 0;
        valid_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            text_in = 64'h1000 + 64'(acc);
            if (ready_in) acc++;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check_int("bp_accepted", acc, 5);
        check("bp_ready_in", {63'd0, ready_in}, 64'd0);
        check("bp_busy", {63'd0, busy}, 64'd1);
        vo0 = vo_count;
        core_stall = 1'b0;
        drain("bp");
        check_int("bp_nout", vo_count - vo0, 5);

        // start while busy is ignored
        cfg(2'd0, 1'b0, 64'h00000000000000A5, 64'd0, 1'b0, 64'd0);
        core_stall = 1'b1;
        push_blk(64'h0000000000000055);
        repeat (4) @(posedge clk);
        #1;
        cfg(2'd3, 1'b1, 64'h000000000000BEEF, 64'h1, 1'b0, 64'd0);
        check("busy_start_err", {63'd0, err_mode}, 64'd0);
        check("busy_start_key", core_key, 64'h00000000000000A5);
        check("busy_start_dir", {63'd0, core_encrypt_decrypt}, 64'd0);
        core_stall = 1'b0;
        drain("busy_start");

        // reset while the core holds a request
        cfg(2'd1, 1'b0, K0, 64'h1234, 1'b0, 64'd0);
        core_stall = 1'b1;
        push_blk(P0);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        vo0 = vo_count;
        core_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_int("rst_mid_nout", vo_count - vo0, 0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_ready", {63'd0, ready_in}, 64'd1);
        check("rst_mid_key", core_key, 64'd0);

        // mode 2: counter mode with the macro, reserved otherwise
        clear_logs();
`ifdef DES_MODE_CTR_EN
        cfg(2'd2, 1'b1, K0, 64'h00000000FFFFFFFF, 1'b0, 64'd0);
        push_blk(P0);
        push_blk(P1);
        drain("ctr");
        check("ctr_core_in0", core_in_log[0], 64'h00000000FFFFFFFF);
        check("ctr_core_in1", core_in_log[1], 64'h0000000000000000);
        check("ctr_err_mode", {63'd0, err_mode}, 64'd0);
`else
        cfg(2'd2, 1'b0, K0, 64'h00000000FFFFFFFF, 1'b0, 64'd0);
        check("mode2_err_mode", {63'd0, err_mode}, 64'd1);
        push_blk(P0);
        drain("mode2");
        check("mode2_core_in", core_in_log[0], P0);
        check("mode2_out", out_log[0], C0);
`endif
        cfg(2'd0, 1'b0, K0, 64'd0, 1'b0, 64'd0);
        check("legal_start_clears_err", {63'd0, err_mode}, 64'd0);

        // randomized sessions with random core latency
        core_lat_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            md = 2'($urandom_range(0, 3));
            k  = ($urandom_range(0, 1) == 0) ? K0 : {$urandom, $urandom};
            v  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) v[31:0] = 32'hFFFFFFFE;
            cfg(md, 1'($urandom), k, v, 1'($urandom), {$urandom, $urandom});
            for (int j = 0; j < int'($urandom_range(1, 7)); j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                case ($urandom_range(0, 3))
                    0:       b = P0;
                    1:       b = C0;
                    2:       b = P1;
                    default: b = {$urandom, $urandom};
                endcase
                push_blk(b);
            end
            drain("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
